// File: rtl/video_pkg.sv
// Shared constants and read-FSM state type for the video line buffer.
// Build option: VLB_PIXEL_DOUBLE_EN (each source pixel is shown for two
// pixel ticks, so only half the words of a line are serialised).
package video_pkg;

    localparam int DATA_W       = 16;
    localparam int DEPTH        = 128;
    localparam int ADDR_W       = 7;
    localparam int ACTIVE_WORDS = 48;
    localparam int PIX_PER_WORD = 8;
    localparam int BIT_W        = $clog2(PIX_PER_WORD);

`ifdef VLB_PIXEL_DOUBLE_EN
    localparam int LINE_WORDS = ACTIVE_WORDS / 2;
`else
    localparam int LINE_WORDS = ACTIVE_WORDS;
`endif

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PREFETCH = 3'd1,
        LOAD     = 3'd2,
        SHIFT    = 3'd3,
        DONE     = 3'd4
    } rd_state_t;

endpackage

// File: rtl/video_line_ram.sv
// Simple dual-port line RAM holding both banks; the address MSB selects
// the bank. Read data is registered and only updates when rd_en is high,
// so the output register doubles as the one-word prefetch stage.
module video_line_ram
    import video_pkg::*;
#(
    parameter int WORD_W = DATA_W,
    parameter int RAM_AW = ADDR_W + 1
) (
    input  logic              i_clk,
    input  logic              wr_en,
    input  logic [RAM_AW-1:0] wr_addr,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [RAM_AW-1:0] rd_addr,
    output logic [WORD_W-1:0] rd_data
);

    logic [WORD_W-1:0] mem [2**RAM_AW];
    logic [WORD_W-1:0] rd_data_reg;

    // Write port
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port, held when not enabled
    always_ff @(posedge i_clk) begin
        if (rd_en) begin
            rd_data_reg <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/video_line_buf.sv
// Ping-pong line buffer: captures one SDRAM line into the write bank while
// the other bank is serialised MSB-first into 2-bit {plane1, plane0} pixels.
// Build option: VLB_PIXEL_DOUBLE_EN (pixel doubling via a phase toggle).
module video_line_buf
    import video_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic [DATA_W-1:0] i_vdata,
    input  logic              i_vdata_valid,
    input  logic              i_vdata_reset,
    input  logic              i_line_start,
    input  logic              i_pix_ce,
    input  logic              i_hactive,
    output logic [1:0]        o_pix,
    output logic              o_pix_valid,
    output logic              o_overrun,
    output logic              o_underrun
);

    localparam logic [ADDR_W:0]   WR_FULL   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(LINE_WORDS - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(PIX_PER_WORD - 1);

    logic              rd_bank_reg;
    logic [ADDR_W:0]   wr_ptr_reg;
    logic              overrun_reg;
    logic              underrun_reg;
    rd_state_t         state_reg;
    logic [DATA_W-1:0] shift_reg;
    logic [BIT_W-1:0]  bit_cnt_reg;
    logic [ADDR_W-1:0] word_cnt_reg;
    logic [1:0]        pix_reg;
    logic              pix_valid_reg;
`ifdef VLB_PIXEL_DOUBLE_EN
    logic              phase_reg;
`endif

    logic              wr_en;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_ptr;
    logic [DATA_W-1:0] ram_rd_data;
    logic              advance;
    logic              step_word;
    logic [1:0]        cur_pix;
    logic [1:0]        pix_sel [PIX_PER_WORD];

    // Pixel n of the shift word: plane bits taken MSB first from each byte
    for (genvar gi = 0; gi < PIX_PER_WORD; gi++) begin : g_pix_sel
        assign pix_sel[gi] = {shift_reg[DATA_W - 1 - gi], shift_reg[DATA_W/2 - 1 - gi]};
    end
    assign cur_pix = pix_sel[bit_cnt_reg];

`ifdef VLB_PIXEL_DOUBLE_EN
    assign advance = phase_reg;
`else
    assign advance = 1'b1;
`endif

    // A word boundary inside the line: swap in the prefetched word
    assign step_word = (state_reg == SHIFT) && !i_line_start && i_pix_ce && i_hactive
                       && advance && (bit_cnt_reg == LAST_BIT) && (word_cnt_reg != LAST_WORD);

    // A word arriving together with line start is dropped: its bank is about to flip
    assign wr_en = i_vdata_valid && !i_vdata_reset && !i_line_start && (wr_ptr_reg != WR_FULL);

    // Read address: word 0 in PREFETCH, word 1 in LOAD, then two ahead of the shifter
    always_comb begin
        rd_en  = 1'b0;
        rd_ptr = '0;
        if (!i_line_start) begin
            case (state_reg)
                PREFETCH: begin
                    rd_en  = 1'b1;
                    rd_ptr = '0;
                end
                LOAD: begin
                    rd_en  = 1'b1;
                    rd_ptr = ADDR_W'(1);
                end
                SHIFT: begin
                    rd_en  = step_word;
                    rd_ptr = word_cnt_reg + ADDR_W'(2);
                end
                default: ;
            endcase
        end
    end

    video_line_ram #(
        .WORD_W (DATA_W),
        .RAM_AW (ADDR_W + 1)
    ) u_ram (
        .i_clk   (i_clk),
        .wr_en   (wr_en),
        .wr_addr ({~rd_bank_reg, wr_ptr_reg[ADDR_W-1:0]}),
        .wr_data (i_vdata),
        .rd_en   (rd_en),
        .rd_addr ({rd_bank_reg, rd_ptr}),
        .rd_data (ram_rd_data)
    );

    // Write pointer: cleared by fetch reset or line start, saturates at DEPTH
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            wr_ptr_reg  <= '0;
            overrun_reg <= 1'b0;
        end else begin
            overrun_reg <= 1'b0;
            if (i_vdata_reset || i_line_start) begin
                wr_ptr_reg <= '0;
            end else if (i_vdata_valid) begin
                if (wr_ptr_reg != WR_FULL) begin
                    wr_ptr_reg <= wr_ptr_reg + 1'b1;
                end else begin
                    overrun_reg <= 1'b1;
                end
            end
        end
    end

    // Bank swap and read FSM; line start overrides any other read activity
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            rd_bank_reg   <= 1'b0;
            state_reg     <= IDLE;
            shift_reg     <= '0;
            bit_cnt_reg   <= '0;
            word_cnt_reg  <= '0;
            pix_reg       <= 2'b00;
            pix_valid_reg <= 1'b0;
            underrun_reg  <= 1'b0;
`ifdef VLB_PIXEL_DOUBLE_EN
            phase_reg     <= 1'b0;
`endif
        end else begin
            underrun_reg <= 1'b0;
            if (i_line_start) begin
                rd_bank_reg   <= ~rd_bank_reg;
                state_reg     <= PREFETCH;
                pix_reg       <= 2'b00;
                pix_valid_reg <= 1'b0;
                underrun_reg  <= (state_reg == PREFETCH) || (state_reg == LOAD)
                                 || (state_reg == SHIFT);
            end else begin
                case (state_reg)
                    PREFETCH: state_reg <= LOAD;
                    LOAD: begin
                        shift_reg    <= ram_rd_data;
                        bit_cnt_reg  <= '0;
                        word_cnt_reg <= '0;
`ifdef VLB_PIXEL_DOUBLE_EN
                        phase_reg    <= 1'b0;
`endif
                        state_reg    <= SHIFT;
                    end
                    SHIFT: begin
                        if (i_pix_ce) begin
                            if (i_hactive) begin
                                pix_reg       <= cur_pix;
                                pix_valid_reg <= 1'b1;
`ifdef VLB_PIXEL_DOUBLE_EN
                                phase_reg     <= ~phase_reg;
`endif
                                if (advance) begin
                                    if (bit_cnt_reg == LAST_BIT) begin
                                        bit_cnt_reg <= '0;
                                        if (word_cnt_reg == LAST_WORD) begin
                                            state_reg <= DONE;
                                        end else begin
                                            shift_reg    <= ram_rd_data;
                                            word_cnt_reg <= word_cnt_reg + 1'b1;
                                        end
                                    end else begin
                                        bit_cnt_reg <= bit_cnt_reg + 1'b1;
                                    end
                                end
                            end else begin
                                pix_reg       <= 2'b00;
                                pix_valid_reg <= 1'b0;
                            end
                        end
                    end
                    DONE: begin
                        if (i_pix_ce) begin
                            pix_reg       <= 2'b00;
                            pix_valid_reg <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_pix       = pix_reg;
    assign o_pix_valid = pix_valid_reg;
    assign o_overrun   = overrun_reg;
    assign o_underrun  = underrun_reg;

endmodule

// File: tb/tb_video_line_buf.sv
// Directed bench for video_line_buf: fill/serialise, fetch reset, overrun,
// underrun, pixel-enable gaps and mid-line reset.
module tb_video_line_buf;

`ifdef VLB_PIXEL_DOUBLE_EN
    localparam int REP = 2;
`else
    localparam int REP = 1;
`endif
    localparam int LINE_PX = 384;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] vdata;
    logic        vdata_valid;
    logic        vdata_reset;
    logic        line_start;
    logic        pix_ce;
    logic        hactive;
    logic [1:0]  o_pix;
    logic        o_pix_valid;
    logic        o_overrun;
    logic        o_underrun;

    int checks = 0;
    int errors = 0;

    logic [1:0] cap  [$];
    logic [1:0] expq [$];

    always #5 clk = ~clk;

    video_line_buf dut (
        .i_clk         (clk),
        .i_reset_n     (reset_n),
        .i_vdata       (vdata),
        .i_vdata_valid (vdata_valid),
        .i_vdata_reset (vdata_reset),
        .i_line_start  (line_start),
        .i_pix_ce      (pix_ce),
        .i_hactive     (hactive),
        .o_pix         (o_pix),
        .o_pix_valid   (o_pix_valid),
        .o_overrun     (o_overrun),
        .o_underrun    (o_underrun)
    );

    function automatic logic [1:0] pix_of(input logic [15:0] w, input int i);
        return {w[15-i], w[7-i]};
    endfunction

    task automatic push_word(input logic [15:0] w);
        for (int i = 0; i < 8; i++) begin
            for (int r = 0; r < REP; r++) begin
                expq.push_back(pix_of(w, i));
            end
        end
    endtask

    function automatic int seq_bad(input int n);
        int b;
        b = 0;
        if (cap.size() < n || expq.size() < n) return n;
        for (int i = 0; i < n; i++) begin
            if (cap[i] !== expq[i]) b++;
        end
        return b;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, n_bad, ov, ufirst, ucnt, ovpos, hbad, extra;

        reset_n = 1'b0; vdata = '0; vdata_valid = 1'b0; vdata_reset = 1'b0;
        line_start = 1'b0; pix_ce = 1'b0; hactive = 1'b0;
        repeat (3) cyc();

        checks++;
        assert (o_pix === 2'b00) else begin errors++; $error("FAIL rst_pix: observed %0d expected 0", o_pix); end
        checks++;
        assert (o_pix_valid === 1'b0) else begin errors++; $error("FAIL rst_valid: observed %0d expected 0", o_pix_valid); end
        checks++;
        assert (o_overrun === 1'b0) else begin errors++; $error("FAIL rst_overrun: observed %0d expected 0", o_overrun); end
        checks++;
        assert (o_underrun === 1'b0) else begin errors++; $error("FAIL rst_underrun: observed %0d expected 0", o_underrun); end
        reset_n = 1'b1;
        cyc();

        // Fill bank 1 with 0xFF00+n
        ov = 0;
        vdata_valid = 1'b1;
        for (int n = 0; n < 48; n++) begin
            vdata = 16'(16'hFF00 + n);
            cyc();
            ov += int'(o_overrun);
        end
        vdata_valid = 1'b0;
        cyc();
        ov += int'(o_overrun);
        checks++;
        assert (ov === 0) else begin errors++; $error("FAIL fill_overrun: observed %0d expected 0", ov); end

        // Line 1: pixel enable every cycle
        expq.delete(); cap.delete();
        for (int n = 0; n < 48 / REP; n++) push_word(16'(16'hFF00 + n));
        pix_ce = 1'b1; hactive = 1'b1; line_start = 1'b1;
        cyc();
        line_start = 1'b0;
        lat = -1;
        for (int c = 1; c <= 800 && cap.size() < LINE_PX; c++) begin
            cyc();
            if (o_pix_valid) begin
                if (lat < 0) lat = c;
                cap.push_back(o_pix);
            end
        end
        checks++;
        assert (lat === 3) else begin errors++; $error("FAIL latency: observed %0d expected 3", lat); end
        n_bad = 0;
        for (int i = 0; i < 8; i++) begin
            if (cap.size() <= i) n_bad++;
            else if (cap[i] !== 2'b10) n_bad++;
        end
        checks++;
        assert (n_bad === 0) else begin errors++; $error("FAIL first8: observed %0d bad pixels expected 0", n_bad); end
        checks++;
        assert (cap.size() === LINE_PX) else begin errors++; $error("FAIL line1_count: observed %0d expected %0d", cap.size(), LINE_PX); end
        n_bad = seq_bad(LINE_PX);
        checks++;
        assert (n_bad === 0) else begin errors++; $error("FAIL line1_seq: observed %0d bad pixels expected 0", n_bad); end
        extra = 0;
        repeat (4) begin
            cyc();
            if (o_pix_valid !== 1'b0 || o_pix !== 2'b00) extra++;
        end
        checks++;
        assert (extra === 0) else begin errors++; $error("FAIL done_idle: observed %0d active cycles expected 0", extra); end

        // Bank 0: five words, fetch reset (with valid high), then three words at 0..2
        pix_ce = 1'b0;
        vdata_valid = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            vdata = 16'(16'h1111 * k);
            cyc();
        end
        vdata = 16'hDEAD; vdata_reset = 1'b1;
        cyc(); cyc();
        vdata_reset = 1'b0;
        vdata = 16'h8001; cyc();
        vdata = 16'h1234; cyc();
        vdata = 16'h5678; cyc();
        vdata_valid = 1'b0;
        expq.delete(); cap.delete();
        push_word(16'h8001); push_word(16'h1234); push_word(16'h5678);
        push_word(16'h4444); push_word(16'h5555);

        // Line 2: pixel enable 1-in-4 with a hactive gap mid-word
        hactive = 1'b1; line_start = 1'b1;
        cyc();
        line_start = 1'b0;
        checks++;
        assert (o_underrun === 1'b0) else begin errors++; $error("FAIL ls_no_underrun: observed %0d expected 0", o_underrun); end
        hbad = 0;
        for (int c = 1; c <= 3000 && cap.size() < 100; c++) begin
            pix_ce  = (c % 4 == 1);
            hactive = !(c >= 41 && c < 51);
            cyc();
            if (pix_ce) begin
                if (!hactive) begin
                    if (o_pix_valid !== 1'b0 || o_pix !== 2'b00) hbad++;
                end else if (o_pix_valid) begin
                    cap.push_back(o_pix);
                end
            end
        end
        checks++;
        assert (hbad === 0) else begin errors++; $error("FAIL hactive_gap: observed %0d active ticks expected 0", hbad); end
        checks++;
        assert (cap.size() === 100) else begin errors++; $error("FAIL line2_count: observed %0d expected 100", cap.size()); end
        n_bad = seq_bad(40 * REP);
        checks++;
        assert (n_bad === 0) else begin errors++; $error("FAIL line2_seq: observed %0d bad pixels expected 0", n_bad); end

        // Line 3 starts after 100 pixels: underrun, reads bank 1 from addr 0
        pix_ce = 1'b1; hactive = 1'b1; line_start = 1'b1;
        cyc();
        line_start = 1'b0;
        ufirst = int'(o_underrun);
        ucnt = ufirst;
        expq.delete(); cap.delete();
        push_word(16'hFF00); push_word(16'hFF01);
        for (int c = 1; c <= 200 && cap.size() < 16 * REP; c++) begin
            cyc();
            ucnt += int'(o_underrun);
            if (o_pix_valid) cap.push_back(o_pix);
        end
        checks++;
        assert (ufirst === 1) else begin errors++; $error("FAIL underrun_pulse: observed %0d expected 1", ufirst); end
        checks++;
        assert (ucnt === 1) else begin errors++; $error("FAIL underrun_count: observed %0d expected 1", ucnt); end
        n_bad = seq_bad(16 * REP);
        checks++;
        assert (n_bad === 0) else begin errors++; $error("FAIL line3_seq: observed %0d bad pixels expected 0", n_bad); end

        // Overrun: 129 words into bank 0
        pix_ce = 1'b0;
        vdata_reset = 1'b1; cyc(); vdata_reset = 1'b0;
        ov = 0; ovpos = 0;
        vdata_valid = 1'b1;
        for (int n = 1; n <= 129; n++) begin
            vdata = 16'(16'hA500 + n);
            cyc();
            if (o_overrun) begin ov++; ovpos = n; end
        end
        vdata_valid = 1'b0;
        cyc();
        if (o_overrun) ov++;
        checks++;
        assert (ov === 1) else begin errors++; $error("FAIL overrun_count: observed %0d expected 1", ov); end
        checks++;
        assert (ovpos === 129) else begin errors++; $error("FAIL overrun_pos: observed %0d expected 129", ovpos); end

        // Line 4 reads the overrun fill, then reset mid-line
        pix_ce = 1'b1; hactive = 1'b1; line_start = 1'b1;
        cyc();
        line_start = 1'b0;
        expq.delete(); cap.delete();
        push_word(16'hA501); push_word(16'hA502);
        for (int c = 1; c <= 200 && cap.size() < 16 * REP; c++) begin
            cyc();
            if (o_pix_valid) cap.push_back(o_pix);
        end
        n_bad = seq_bad(16 * REP);
        checks++;
        assert (n_bad === 0) else begin errors++; $error("FAIL line4_seq: observed %0d bad pixels expected 0", n_bad); end
        reset_n = 1'b0;
        cyc();
        checks++;
        assert (o_pix_valid === 1'b0) else begin errors++; $error("FAIL midrst_valid: observed %0d expected 0", o_pix_valid); end
        reset_n = 1'b1;
        extra = 0;
        repeat (6) begin
            cyc();
            if (o_pix_valid !== 1'b0) extra++;
        end
        checks++;
        assert (extra === 0) else begin errors++; $error("FAIL midrst_idle: observed %0d valid cycles expected 0", extra); end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
